// File: rtl/m8_32_gearbox_if.sv
// Beat-in / word-out stream bundle for the narrow-to-wide gearbox.
// The slave side is the gearbox; the master side feeds beats and drains words.
interface m8_32_gearbox_if #(
   parameter int IN_W  = 8,
   parameter int RATIO = 4
);
   logic [IN_W-1:0]       in_data;
   logic                  in_valid;
   logic                  in_last;
   logic                  in_ready;
   logic [IN_W*RATIO-1:0] out_data;
   logic [RATIO-1:0]      out_keep;
   logic                  out_last;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_keep, out_last, out_valid
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_keep, out_last, out_valid
   );
endinterface

// File: rtl/m8_32_gearbox.sv
// Packs RATIO beats of IN_W bits into one wide word with valid/ready on both sides,
// closing partial words on in_last with PAD fill and a per-lane keep mask.
module m8_32_gearbox #(
   parameter int              IN_W      = 8,
   parameter int              RATIO     = 4,
   parameter bit              MSB_FIRST = 1'b1,
   parameter logic [IN_W-1:0] PAD       = '0
) (
   input logic            clk_32f,
   input logic            reset,
   m8_32_gearbox_if.slave bus
);
   localparam int OUT_W = IN_W * RATIO;
   localparam int CW    = $clog2(RATIO);
   localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

   logic [CW-1:0]    cnt;
   logic [OUT_W-1:0] asm_q;
   logic [OUT_W-1:0] data_q;
   logic [RATIO-1:0] keep_q;
   logic             last_q;
   logic             valid_q;

   logic [OUT_W-1:0] word_next;
   logic [RATIO-1:0] keep_next;
   logic             completing;
   logic             accept;
   logic             ready;
   int               lane;

   assign completing = (cnt == CNT_MAX) || bus.in_last;
   assign ready      = ((cnt != CNT_MAX) && !bus.in_last) || !valid_q || bus.out_ready;
   assign accept     = bus.in_valid && ready;

   // Merge the incoming beat into the lanes gathered so far; untouched lanes take PAD.
   always_comb begin
      word_next = '0;
      keep_next = '0;
      lane      = MSB_FIRST ? (RATIO - 1 - int'(cnt)) : int'(cnt);
      for (int i = 0; i < RATIO; i++) begin
         keep_next[i] = MSB_FIRST ? (i >= lane) : (i <= lane);
         if (i == lane)
            word_next[i*IN_W +: IN_W] = bus.in_data;
         else if (keep_next[i])
            word_next[i*IN_W +: IN_W] = asm_q[i*IN_W +: IN_W];
         else
            word_next[i*IN_W +: IN_W] = PAD;
      end
   end

   // A completing beat reloads the output register even while it is being drained,
   // so back-to-back words leave no bubble.
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         cnt     <= '0;
         asm_q   <= '0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         if (valid_q && bus.out_ready)
            valid_q <= 1'b0;
         if (accept) begin
            if (completing) begin
               data_q  <= word_next;
               keep_q  <= keep_next;
               last_q  <= bus.in_last;
               valid_q <= 1'b1;
               asm_q   <= '0;
               cnt     <= '0;
            end else begin
               asm_q <= word_next;
               cnt   <= cnt + CW'(1);
            end
         end
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_data  = data_q;
   assign bus.out_keep  = keep_q;
   assign bus.out_last  = last_q;
   assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_m8_32_gearbox.sv
// Directed bench for m8_32_gearbox: an MSB-first and an LSB-first instance share one
// stimulus stream; vector rows cover the common cases, hand sequences the corners.
module tb_m8_32_gearbox;
   logic clk_32f = 1'b0;
   logic reset   = 1'b1;

   int total = 0;
   int bad   = 0;

   m8_32_gearbox_if #(.IN_W(8), .RATIO(4)) bus_m ();
   m8_32_gearbox_if #(.IN_W(8), .RATIO(4)) bus_l ();

   assign bus_l.in_data   = bus_m.in_data;
   assign bus_l.in_valid  = bus_m.in_valid;
   assign bus_l.in_last   = bus_m.in_last;
   assign bus_l.out_ready = bus_m.out_ready;

   m8_32_gearbox #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1), .PAD(8'h00)) dut_msb (
      .clk_32f (clk_32f),
      .reset   (reset),
      .bus     (bus_m)
   );

   m8_32_gearbox #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b0), .PAD(8'h00)) dut_lsb (
      .clk_32f (clk_32f),
      .reset   (reset),
      .bus     (bus_l)
   );

   always #5 clk_32f = ~clk_32f;

   typedef struct {
      logic [7:0]  d;
      logic        v;
      logic        l;
      logic        ordy;
      logic        exp_ir;
      logic        exp_ov;
      logic        chk_word;
      logic [31:0] exp_data;
      logic [3:0]  exp_keep;
      logic        exp_last;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [7:0] d, input logic v, input logic l,
                               input logic ordy, input logic ir, input logic ov,
                               input logic chk, input logic [31:0] data,
                               input logic [3:0] keep, input logic last);
      vec_t r;
      r.d = d; r.v = v; r.l = l; r.ordy = ordy; r.exp_ir = ir; r.exp_ov = ov;
      r.chk_word = chk; r.exp_data = data; r.exp_keep = keep; r.exp_last = last;
      return r;
   endfunction

   task automatic applyStimulus(input logic [7:0] d, input logic v, input logic l,
                                input logic ordy);
      bus_m.in_data   = d;
      bus_m.in_valid  = v;
      bus_m.in_last   = l;
      bus_m.out_ready = ordy;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   // Inputs settle just after an edge; in_ready is checked before the next edge,
   // registered outputs just after it.
   task automatic runRow(input vec_t r, input int idx);
      string tag;
      tag = $sformatf("row%0d", idx);
      applyStimulus(r.d, r.v, r.l, r.ordy);
      #1;
      checkOutput({tag, ".in_ready"}, 32'(bus_m.in_ready), 32'(r.exp_ir));
      @(posedge clk_32f);
      #1;
      checkOutput({tag, ".out_valid"}, 32'(bus_m.out_valid), 32'(r.exp_ov));
      if (r.chk_word) begin
         checkOutput({tag, ".out_data"}, bus_m.out_data, r.exp_data);
         checkOutput({tag, ".out_keep"}, 32'(bus_m.out_keep), 32'(r.exp_keep));
         checkOutput({tag, ".out_last"}, 32'(bus_m.out_last), 32'(r.exp_last));
      end
   endtask

   task automatic tick();
      @(posedge clk_32f);
      #1;
   endtask

   initial begin
      logic [31:0] exp_word;
      logic [7:0]  d;

      // full word, MSB first
      vecs.push_back(mk(8'h11, 1, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'h22, 1, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'h33, 1, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'h44, 1, 0, 1, 1, 1, 1, 32'h11223344, 4'hF, 0));
      vecs.push_back(mk(8'h00, 0, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      // partial close-out, next word restarts at the top lane
      vecs.push_back(mk(8'hAA, 1, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'hBB, 1, 1, 1, 1, 1, 1, 32'hAABB0000, 4'hC, 1));
      vecs.push_back(mk(8'hCC, 1, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'hDD, 1, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'hEE, 1, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'hFF, 1, 0, 1, 1, 1, 1, 32'hCCDDEEFF, 4'hF, 0));
      vecs.push_back(mk(8'h00, 0, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      // backpressure: word held, three beats absorbed, fourth stalls
      vecs.push_back(mk(8'h01, 1, 0, 0, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'h02, 1, 0, 0, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'h03, 1, 0, 0, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'h04, 1, 0, 0, 1, 1, 1, 32'h01020304, 4'hF, 0));
      vecs.push_back(mk(8'h05, 1, 0, 0, 1, 1, 1, 32'h01020304, 4'hF, 0));
      vecs.push_back(mk(8'h06, 1, 0, 0, 1, 1, 1, 32'h01020304, 4'hF, 0));
      vecs.push_back(mk(8'h07, 1, 0, 0, 1, 1, 1, 32'h01020304, 4'hF, 0));
      vecs.push_back(mk(8'h08, 1, 0, 0, 0, 1, 1, 32'h01020304, 4'hF, 0));
      vecs.push_back(mk(8'h08, 1, 0, 1, 1, 1, 1, 32'h05060708, 4'hF, 0));
      vecs.push_back(mk(8'h00, 0, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      // single-beat packets: in_last stalls behind a held word, then drain+reload
      vecs.push_back(mk(8'hA1, 1, 1, 0, 1, 1, 1, 32'hA1000000, 4'h8, 1));
      vecs.push_back(mk(8'hA2, 1, 1, 0, 0, 1, 1, 32'hA1000000, 4'h8, 1));
      vecs.push_back(mk(8'hA2, 1, 1, 1, 1, 1, 1, 32'hA2000000, 4'h8, 1));
      vecs.push_back(mk(8'h00, 0, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      // partial word held across idle cycles
      vecs.push_back(mk(8'hB1, 1, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'h5A, 0, 1, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'h00, 0, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'hB2, 1, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'hB3, 1, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'hB4, 1, 0, 1, 1, 1, 1, 32'hB1B2B3B4, 4'hF, 0));
      vecs.push_back(mk(8'h00, 0, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      // in_last on the fourth beat gives a full word marked last
      vecs.push_back(mk(8'h01, 1, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'h02, 1, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'h03, 1, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));
      vecs.push_back(mk(8'h04, 1, 1, 1, 1, 1, 1, 32'h01020304, 4'hF, 1));
      vecs.push_back(mk(8'h00, 0, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0));

      applyStimulus(8'h00, 0, 0, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk_32f);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("reset.out_valid", 32'(bus_m.out_valid), 32'd0);
      checkOutput("reset.out_data", bus_m.out_data, 32'h0);
      checkOutput("reset.out_keep", 32'(bus_m.out_keep), 32'h0);
      checkOutput("reset.out_last", 32'(bus_m.out_last), 32'h0);
      checkOutput("reset.in_ready", 32'(bus_m.in_ready), 32'h1);

      for (int i = 0; i < vecs.size(); i++)
         runRow(vecs[i], i);

      // continuous stream: in_ready never drops, a word every fourth cycle
      exp_word = '0;
      for (int k = 0; k < 12; k++) begin
         d = 8'h10 + 8'(k);
         exp_word = {exp_word[23:0], d};
         applyStimulus(d, 1, 0, 1);
         #1;
         checkOutput($sformatf("stream%0d.in_ready", k), 32'(bus_m.in_ready), 32'h1);
         tick();
         checkOutput($sformatf("stream%0d.out_valid", k), 32'(bus_m.out_valid),
                     32'((k % 4) == 3));
         if ((k % 4) == 3)
            checkOutput($sformatf("stream%0d.out_data", k), bus_m.out_data, exp_word);
      end
      applyStimulus(8'h00, 0, 0, 1);
      tick();

      // reset mid-word discards the partial beats
      applyStimulus(8'h11, 1, 0, 1);
      tick();
      applyStimulus(8'h22, 1, 0, 1);
      tick();
      applyStimulus(8'h00, 0, 0, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("midreset.out_valid", 32'(bus_m.out_valid), 32'h0);
      checkOutput("midreset.out_data", bus_m.out_data, 32'h0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(8'h55 + 8'(k * 17), 1, 0, 1);
         tick();
         checkOutput($sformatf("postreset%0d.out_valid", k), 32'(bus_m.out_valid),
                     32'(k == 3));
      end
      checkOutput("postreset.out_data", bus_m.out_data, 32'h55667788);
      checkOutput("postreset.out_keep", 32'(bus_m.out_keep), 32'hF);
      applyStimulus(8'h00, 0, 0, 1);
      tick();

      // LSB-first lane order
      for (int k = 0; k < 4; k++) begin
         applyStimulus(8'h11 * 8'(k + 1), 1, 0, 1);
         tick();
      end
      checkOutput("lsb.out_valid", 32'(bus_l.out_valid), 32'h1);
      checkOutput("lsb.out_data", bus_l.out_data, 32'h44332211);
      checkOutput("lsb.out_keep", 32'(bus_l.out_keep), 32'hF);
      applyStimulus(8'h11, 1, 0, 1);
      tick();
      applyStimulus(8'h22, 1, 1, 1);
      tick();
      checkOutput("lsbpart.out_data", bus_l.out_data, 32'h00002211);
      checkOutput("lsbpart.out_keep", 32'(bus_l.out_keep), 32'h3);
      checkOutput("lsbpart.out_last", 32'(bus_l.out_last), 32'h1);
      checkOutput("msbpart.out_data", bus_m.out_data, 32'h11220000);
      checkOutput("msbpart.out_keep", 32'(bus_m.out_keep), 32'hC);
      applyStimulus(8'h00, 0, 0, 1);
      tick();
      checkOutput("lsbdrain.out_valid", 32'(bus_l.out_valid), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
